// File: rtl/beta_id_pkg.sv
// Shared definitions for the Beta decode stage: opcodes, the bubble
// instruction, PC-select codes, trap addresses and opcode classifiers.
package beta_id_pkg;

    // Bubble instruction ADD(R31,R31,R31): reads only R31, so it never interlocks.
    localparam logic [31:0] NOP_WORD   = 32'h83FF_F800;
    localparam logic [4:0]  XP_REG     = 5'd30;
    localparam logic [4:0]  R31        = 5'd31;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
    localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
    localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1D;
    localparam logic [5:0] OP_BNE = 6'h1E;
    localparam logic [5:0] OP_LDR = 6'h1F;

    typedef enum logic [2:0] {
        PCSEL_NEXT  = 3'd0,
        PCSEL_BR    = 3'd1,
        PCSEL_JMP   = 3'd2,
        PCSEL_ILLOP = 3'd3,
        PCSEL_XADR  = 3'd4
    } pcSel_t;

    // Holes at 0x23, 0x2F, 0x33 and 0x3F are unimplemented operations.
    function automatic logic isLegal(input logic [5:0] op);
        return op inside {OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR,
                          [6'h20:6'h22], [6'h24:6'h2E],
                          [6'h30:6'h32], [6'h34:6'h3E]};
    endfunction

    // Register-register ALU forms take their second operand from Rb.
    function automatic logic usesRb(input logic [5:0] op);
        return isLegal(op) && (op inside {[6'h20:6'h2E]});
    endfunction

endpackage

// File: rtl/beta_regfile.sv
// Beta register file: 31 storage words plus hard-wired R31 = 0.
// Three combinational read ports (A, B, store data) and one write port;
// a write in the same cycle is visible on the read ports (write-through).
module beta_regfile
    import beta_id_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  wAddr,
    input  logic [31:0] wData,
    input  logic [4:0]  aAddr,
    output logic [31:0] aData,
    input  logic [4:0]  bAddr,
    output logic [31:0] bData,
    input  logic [4:0]  cAddr,
    output logic [31:0] cData
);

    logic [31:0] regs [0:30];
    logic        wrValid;

    assign wrValid = we && (wAddr != R31);

    // Write port; writes aimed at R31 are dropped.
    // NOTE: register-file storage has no reset -- software initialises it, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wrValid) begin
            regs[wAddr] <= wData;
        end
    end

    function automatic logic [31:0] readReg(input logic [4:0] addr);
        if (addr == R31) begin
            return 32'h0;
        end else if (wrValid && (wAddr == addr)) begin
            return wData;
        end else begin
            return regs[addr];
        end
    endfunction

    // Read ports with R31 zero and same-cycle write-through.
    always_comb begin
        aData = readReg(aAddr);
        bData = readReg(bAddr);
        cData = readReg(cAddr);
    end

endmodule

// File: rtl/beta_id.sv
// Beta instruction-decode / register-read stage.
// Holds the IF/ID register, reads operands, resolves BEQ/BNE/JMP/illegal
// opcodes, drives the fetch stall and loads the ID/EX register.
// Build option: define BETA_ID_BYPASS_EN to forward EX/MEM results instead
// of interlocking (only load-use then stalls).
module beta_id
    import beta_id_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc_plus4,
    input  logic [31:0] if_ir,
    output logic        stall,
    output logic [2:0]  pcsel,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target,
    input  logic        wb_we,
    input  logic [4:0]  wb_rc,
    input  logic [31:0] wb_data,
    input  logic [4:0]  ex_dest,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] ex_fwd,
    input  logic [31:0] mem_fwd,
    output logic [31:0] ex_ir,
    output logic [31:0] ex_pc_plus4,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_d,
    output logic        ex_trap
);

    // IF/ID pipeline register
    logic [31:0] idIr;
    logic [31:0] idPc4;

    // Decoded fields
    logic [5:0]  op;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] litSext;
    logic [31:0] litSext4;
    logic        legal;
    logic        useRa;
    logic        useRb;
    logic        useRc;

    // Operands: raw register-file values and the (possibly forwarded) values used
    logic [31:0] rfA;
    logic [31:0] rfB;
    logic [31:0] rfC;
    logic [31:0] aVal;
    logic [31:0] bVal;
    logic [31:0] cVal;

    pcSel_t      pcSelNext;
    logic [31:0] exANext;
    logic [31:0] exBNext;

    assign op       = idIr[31:26];
    assign rc       = idIr[25:21];
    assign ra       = idIr[20:16];
    assign rb       = idIr[15:11];
    assign litSext  = {{16{idIr[15]}}, idIr[15:0]};
    assign litSext4 = {litSext[29:0], 2'b00};
    assign legal    = isLegal(op);
    assign useRa    = legal;
    assign useRb    = usesRb(op);
    assign useRc    = (op == OP_ST);

    beta_regfile uRegfile (
        .clk   (clk),
        .we    (wb_we),
        .wAddr (wb_rc),
        .wData (wb_data),
        .aAddr (ra),
        .aData (rfA),
        .bAddr (rb),
        .bData (rfB),
        .cAddr (rc),
        .cData (rfC)
    );

    // A used source other than R31 that names a register still in flight.
    function automatic logic srcHit(input logic used, input logic [4:0] idx,
                                    input logic [4:0] dest);
        return used && (idx != R31) && (idx == dest);
    endfunction

`ifdef BETA_ID_BYPASS_EN
    // Youngest producer wins: EX before MEM before the register file.
    function automatic logic [31:0] pickSrc(input logic used, input logic [4:0] idx,
                                            input logic [31:0] rfVal);
        if (srcHit(used, idx, ex_dest)) begin
            return ex_fwd;
        end else if (srcHit(used, idx, mem_dest)) begin
            return mem_fwd;
        end else begin
            return rfVal;
        end
    endfunction

    assign aVal  = pickSrc(useRa, ra, rfA);
    assign bVal  = pickSrc(useRb, rb, rfB);
    assign cVal  = pickSrc(useRc, rc, rfC);

    // A load in EX has no data yet, so only load-use must wait.
    assign stall = ex_is_load && (srcHit(useRa, ra, ex_dest) ||
                                  srcHit(useRb, rb, ex_dest) ||
                                  srcHit(useRc, rc, ex_dest));
`else
    logic unusedFwd;
    assign unusedFwd = ^{ex_fwd, mem_fwd, ex_is_load};

    assign aVal  = rfA;
    assign bVal  = rfB;
    assign cVal  = rfC;

    // Full interlock: wait until the producer has left MEM and reached WB.
    assign stall = srcHit(useRa, ra, ex_dest) || srcHit(useRa, ra, mem_dest) ||
                   srcHit(useRb, rb, ex_dest) || srcHit(useRb, rb, mem_dest) ||
                   srcHit(useRc, rc, ex_dest) || srcHit(useRc, rc, mem_dest);
`endif

    // Branch/jump resolution; nothing redirects while the operands are not ready.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        pcSelNext = PCSEL_NEXT;
        if (!stall) begin
            if (!legal) begin
                pcSelNext = PCSEL_ILLOP;
            end else begin
                case (op)
                    OP_BEQ:  if (aVal == 32'h0) pcSelNext = PCSEL_BR;
                    OP_BNE:  if (aVal != 32'h0) pcSelNext = PCSEL_BR;
                    OP_JMP:  pcSelNext = PCSEL_JMP;
                    default: pcSelNext = PCSEL_NEXT;
                endcase
            end
        end
    end

    assign pcsel         = pcSelNext;
    assign branch_target = idPc4 + litSext4;
    assign jump_target   = aVal & 32'hFFFF_FFFC;

    // Operand selection for EX: LDR is PC-relative, immediates replace Rb.
    always_comb begin
        exANext = aVal;
        exBNext = litSext;
        if (op == OP_LDR) begin
            exANext = idPc4;
            exBNext = litSext4;
        end else if (useRb) begin
            exBNext = bVal;
        end
    end

    // IF/ID register: hold on stall, annul the wrong-path fetch on a redirect.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idIr  <= NOP_WORD;
            idPc4 <= 32'h0;
        end else if (!stall) begin
            idIr  <= (pcSelNext != PCSEL_NEXT) ? NOP_WORD : if_ir;
            idPc4 <= if_pc_plus4;
        end
    end

    // ID/EX register: a stall sends a zeroed bubble down the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ir       <= NOP_WORD;
            ex_pc_plus4 <= 32'h0;
            ex_a        <= 32'h0;
            ex_b        <= 32'h0;
            ex_d        <= 32'h0;
            ex_trap     <= 1'b0;
        end else if (stall) begin
            ex_ir       <= NOP_WORD;
            ex_pc_plus4 <= 32'h0;
            ex_a        <= 32'h0;
            ex_b        <= 32'h0;
            ex_d        <= 32'h0;
            ex_trap     <= 1'b0;
        end else begin
            ex_ir       <= idIr;
            ex_pc_plus4 <= idPc4;
            ex_a        <= exANext;
            ex_b        <= exBNext;
            ex_d        <= cVal;
            ex_trap     <= !legal;
        end
    end

endmodule

// File: tb/tb_beta_id.sv
// Directed bench for beta_id. Expected values are hand-computed; the
// forwarding scenarios switch on BETA_ID_BYPASS_EN to match the build.
module tb_beta_id;
    import beta_id_pkg::*;

    localparam logic [5:0] OP_ADD = 6'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_ir;
    logic        stall;
    logic [2:0]  pcsel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        wb_we;
    logic [4:0]  wb_rc;
    logic [31:0] wb_data;
    logic [4:0]  ex_dest;
    logic        ex_is_load;
    logic [4:0]  mem_dest;
    logic [31:0] ex_fwd;
    logic [31:0] mem_fwd;
    logic [31:0] ex_ir;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_d;
    logic        ex_trap;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    beta_id dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc_plus4   (if_pc_plus4),
        .if_ir         (if_ir),
        .stall         (stall),
        .pcsel         (pcsel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .wb_we         (wb_we),
        .wb_rc         (wb_rc),
        .wb_data       (wb_data),
        .ex_dest       (ex_dest),
        .ex_is_load    (ex_is_load),
        .mem_dest      (mem_dest),
        .ex_fwd        (ex_fwd),
        .mem_fwd       (mem_fwd),
        .ex_ir         (ex_ir),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_d          (ex_d),
        .ex_trap       (ex_trap)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    logic [31:0] wrongPath;
    logic [31:0] beqW, bne1W, bne2W, jmpW, stW, add4W, add6W, ldrW;

    initial begin
        wrongPath = ins(OP_ADD, 5'd1, 5'd1, {5'd1, 11'd0});
        beqW      = ins(OP_BEQ, 5'd31, 5'd1, 16'd3);
        bne1W     = ins(OP_BNE, 5'd31, 5'd1, 16'hFFFF);
        bne2W     = ins(OP_BNE, 5'd31, 5'd2, 16'h0010);
        jmpW      = ins(OP_JMP, 5'd31, 5'd2, 16'h0000);
        stW       = ins(OP_ST,  5'd2,  5'd1, 16'hFFFC);
        add4W     = ins(OP_ADD, 5'd4,  5'd3, {5'd3, 11'd0});
        add6W     = ins(OP_ADD, 5'd6,  5'd5, {5'd31, 11'd0});
        ldrW      = ins(OP_LDR, 5'd7,  5'd31, 16'd2);

        reset       = 1'b1;
        if_ir       = NOP_WORD;
        if_pc_plus4 = 32'h0;
        wb_we       = 1'b0;
        wb_rc       = 5'd31;
        wb_data     = 32'h0;
        ex_dest     = 5'd31;
        ex_is_load  = 1'b0;
        mem_dest    = 5'd31;
        ex_fwd      = 32'h0;
        mem_fwd     = 32'h0;

        // Reset state
        #2;
        check("rst_ex_ir",    ex_ir,       NOP_WORD);
        check("rst_ex_pc4",   ex_pc_plus4, 32'h0);
        check("rst_ex_a",     ex_a,        32'h0);
        check("rst_ex_trap",  ex_trap,     1'b0);
        check("rst_stall",    stall,       1'b0);
        check("rst_pcsel",    pcsel,       3'd0);
        tick();
        tick();
        reset = 1'b0;

        // Preload R1 = 0, R2 = 0x123, R5 = 0x77 through the WB port
        wb_we = 1'b1; wb_rc = 5'd1; wb_data = 32'h0;   tick();
        wb_rc = 5'd2; wb_data = 32'h123;               tick();
        wb_rc = 5'd5; wb_data = 32'h77;                tick();
        wb_we = 1'b0; wb_rc = 5'd31; wb_data = 32'h0;

        // BEQ taken: R1 == 0, target 0x104 + 12
        if_ir = beqW; if_pc_plus4 = 32'h104; tick();
        if_ir = wrongPath; if_pc_plus4 = 32'h108; #1;
        check("beq_pcsel",  pcsel,         3'd1);
        check("beq_target", branch_target, 32'h110);
        check("beq_stall",  stall,         1'b0);
        tick();
        check("beq_ex_ir",  ex_ir,       beqW);
        check("beq_ex_pc4", ex_pc_plus4, 32'h104);
        check("beq_ex_a",   ex_a,        32'h0);
        check("beq_idnop_pcsel", pcsel,  3'd0);
        if_ir = NOP_WORD; if_pc_plus4 = 32'h10C;
        tick();
        check("beq_annul", ex_ir, NOP_WORD);

        // BNE not taken (R1 == 0), negative offset target still computed
        if_ir = bne1W; if_pc_plus4 = 32'h104; tick();
        if_ir = bne2W; if_pc_plus4 = 32'h200; #1;
        check("bne_nt_pcsel",  pcsel,         3'd0);
        check("bne_nt_target", branch_target, 32'h100);
        // BNE taken (R2 != 0)
        tick();
        if_ir = NOP_WORD; if_pc_plus4 = 32'h204; #1;
        check("bne_t_pcsel",  pcsel,         3'd1);
        check("bne_t_target", branch_target, 32'h240);
        tick();

        // JMP R2: target drops the low two bits
        if_ir = jmpW; if_pc_plus4 = 32'h300; tick();
        if_ir = wrongPath; if_pc_plus4 = 32'h304; #1;
        check("jmp_pcsel",  pcsel,       3'd2);
        check("jmp_target", jump_target, 32'h120);
        tick();
        check("jmp_ex_ir", ex_ir, jmpW);
        if_ir = NOP_WORD; if_pc_plus4 = 32'h308;
        tick();
        check("jmp_annul", ex_ir, NOP_WORD);

        // Illegal opcode 0x00
        if_ir = 32'h0; if_pc_plus4 = 32'h400; tick();
        if_ir = NOP_WORD; if_pc_plus4 = 32'h404; #1;
        check("ill_pcsel", pcsel, 3'd3);
        tick();
        check("ill_trap",   ex_trap,     1'b1);
        check("ill_ex_pc4", ex_pc_plus4, 32'h400);
        check("ill_ex_ir",  ex_ir,       32'h0);
        tick();
        check("ill_trap_clear", ex_trap, 1'b0);

        // ST: immediate in ex_b, store data Rc in ex_d
        if_ir = stW; if_pc_plus4 = 32'h500; tick();
        if_ir = NOP_WORD; tick();
        check("st_ex_a", ex_a, 32'h0);
        check("st_ex_b", ex_b, 32'hFFFF_FFFC);
        check("st_ex_d", ex_d, 32'h123);

        // RAW hazard on R3 with the producer in EX
        if_ir = add4W; if_pc_plus4 = 32'h600; tick();
        ex_dest = 5'd3; ex_fwd = 32'h55; if_ir = NOP_WORD; if_pc_plus4 = 32'h604;
`ifndef BETA_ID_BYPASS_EN
        #1;
        check("raw_stall_ex",  stall, 1'b1);
        check("raw_pcsel",     pcsel, 3'd0);
        tick();
        check("raw_bubble1", ex_ir, NOP_WORD);
        ex_dest = 5'd31; mem_dest = 5'd3; #1;
        check("raw_stall_mem", stall, 1'b1);
        tick();
        check("raw_bubble2", ex_ir, NOP_WORD);
        mem_dest = 5'd31; wb_we = 1'b1; wb_rc = 5'd3; wb_data = 32'h55; #1;
        check("raw_release", stall, 1'b0);
        tick();
        wb_we = 1'b0; wb_rc = 5'd31; wb_data = 32'h0;
        check("raw_ex_ir",  ex_ir,       add4W);
        check("raw_ex_pc4", ex_pc_plus4, 32'h600);
`else
        #1;
        check("raw_no_stall", stall, 1'b0);
        tick();
        ex_dest = 5'd31;
        check("raw_ex_ir", ex_ir, add4W);
`endif
        check("raw_ex_a", ex_a, 32'h55);
        check("raw_ex_b", ex_b, 32'h55);

        // Load-use on R5, plus a WB write aimed at R31
        if_ir = add6W; if_pc_plus4 = 32'h700; tick();
        ex_is_load = 1'b1; ex_dest = 5'd5; ex_fwd = 32'hDEAD; if_ir = NOP_WORD; #1;
        check("lu_stall", stall, 1'b1);
        tick();
        check("lu_bubble", ex_ir, NOP_WORD);
        ex_is_load = 1'b0; ex_dest = 5'd31; mem_dest = 5'd5; mem_fwd = 32'h66;
        wb_we = 1'b1; wb_rc = 5'd31; wb_data = 32'hFFFF_FFFF; #1;
`ifndef BETA_ID_BYPASS_EN
        check("lu_stall_mem", stall, 1'b1);
        tick();
        mem_dest = 5'd31; #1;
        check("lu_release", stall, 1'b0);
        tick();
        check("lu_ex_a", ex_a, 32'h77);
`else
        check("lu_release", stall, 1'b0);
        tick();
        check("lu_ex_a", ex_a, 32'h66);
`endif
        check("lu_ex_ir", ex_ir, add6W);
        check("r31_zero", ex_b, 32'h0);
        wb_we = 1'b0; wb_rc = 5'd31; wb_data = 32'h0; mem_dest = 5'd31;

        // LDR: PC-relative operands, then reset asserted during a stall
        if_ir = ldrW; if_pc_plus4 = 32'h800; tick();
        if_ir = add4W; if_pc_plus4 = 32'h804; tick();
        check("ldr_ex_ir", ex_ir, ldrW);
        check("ldr_ex_a",  ex_a,  32'h800);
        check("ldr_ex_b",  ex_b,  32'h8);
        ex_dest = 5'd3; ex_is_load = 1'b1; if_ir = NOP_WORD; #1;
        check("pre_rst_stall", stall, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ex_ir",  ex_ir,       NOP_WORD);
        check("midrst_ex_a",   ex_a,        32'h0);
        check("midrst_ex_pc4", ex_pc_plus4, 32'h0);
        check("midrst_stall",  stall,       1'b0);
        check("midrst_pcsel",  pcsel,       3'd0);
        tick();
        reset = 1'b0; ex_dest = 5'd31; ex_is_load = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/beta_id.md
Name: beta_id

Overview:
- Beta instruction-decode / register-read stage, directly downstream of the instruction-fetch stage.
- Holds the IF/ID pipeline register and reads operands from the 32-entry register file (R31 = 0).
- Resolves BEQ/BNE/JMP and illegal opcodes in ID; drives pcsel, branch and jump targets, and the fetch stall back to IF.
- Registers decoded operands into the ID/EX pipeline register for the execute stage.

Parameters:
NOP_WORD, 32'h83FFF800, bubble instruction ADD(R31,R31,R31) injected on reset, annul and stall.
XP_REG, 5'd30, exception-pointer register index reported with ex_trap.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
if_pc_plus4  input  32  PC+4 of the instruction presented by IF
if_ir  input  32  fetched instruction word
stall  output  1  holds IF PC; also holds the IF/ID register
pcsel  output  3  0 next, 1 branch, 2 jmp, 3 illop, 4 xadr (4 never driven)
branch_target  output  32  id_pc4 + (sext(lit16) << 2)
jump_target  output  32  Ra & 32'hFFFFFFFC
wb_we  input  1  register-file write enable from WB
wb_rc  input  5  WB destination
wb_data  input  32  WB data
ex_dest  input  5  destination in EX (31 = none)
ex_is_load  input  1  EX holds LD/LDR
mem_dest  input  5  destination in MEM (31 = none)
ex_fwd  input  32  EX result (used only with bypass)
mem_fwd  input  32  MEM result (used only with bypass)
ex_ir  output  32  instruction to EX
ex_pc_plus4  output  32  PC+4 to EX
ex_a  output  32  operand A
ex_b  output  32  operand B: Rb, or sext(lit16)
ex_d  output  32  store data (Rc) for ST
ex_trap  output  1  illegal opcode; EX writes ex_pc_plus4 to XP_REG

Behaviour:
- Reset, asynchronous:
  - IF/ID: id_ir = NOP_WORD, id_pc4 = 0.
  - ID/EX: ex_ir = NOP_WORD; ex_pc_plus4, ex_a, ex_b, ex_d = 0; ex_trap = 0.
  - Register file is not reset.
- Field decode: op = ir[31:26], rc = ir[25:21], ra = ir[20:16], rb = ir[15:11], lit16 = ir[15:0].
- Legal opcodes: 0x18 LD, 0x19 ST, 0x1B JMP, 0x1D BEQ, 0x1E BNE, 0x1F LDR, 0x20–0x22, 0x24–0x2E, 0x30–0x32, 0x34–0x3E. Every other opcode is illegal.
- Source registers used:
  - ra: all legal opcodes.
  - rb: opcodes 0x20–0x2E.
  - rc: ST only.
- Register read:
  - Index 31 reads 0.
  - A WB write to the same index in the same cycle is passed through to the read (write-through).
  - A write with wb_rc = 31 is discarded.
- Hazard (no bypass): stall = 1 when any used source index ≠ 31 equals ex_dest or mem_dest.
- Control, evaluated only when stall = 0:
  - BEQ: pcsel = 1 if Ra == 0.
  - BNE: pcsel = 1 if Ra != 0.
  - JMP: pcsel = 2.
  - Illegal opcode: pcsel = 3.
  - Otherwise pcsel = 0. pcsel is forced to 0 while stall = 1.
- IF/ID update each edge:
  - stall: hold.
  - else pcsel ≠ 0: id_ir <= NOP_WORD (annul the wrong-path fetch); id_pc4 <= if_pc_plus4.
  - else: id_ir <= if_ir; id_pc4 <= if_pc_plus4.
- ID/EX update each edge:
  - stall: ex_ir <= NOP_WORD and ex_trap <= 0 (bubble). Other EX fields are don't-care but are set to 0.
  - else: ex_ir <= id_ir, ex_pc_plus4 <= id_pc4, ex_trap <= illegal.
  - ex_a <= Ra, except LDR: ex_a <= id_pc4.
  - ex_b <= Rb for 0x20–0x2E; sext(lit16) for 0x30–0x3E, LD, ST; sext(lit16) << 2 for LDR.
  - ex_d <= Rc.
- Arithmetic: 32-bit, wrap-around, no overflow flag. Branch target is computed even when the branch is not taken.
- Reset asserted mid-stall: outputs take reset values at once; stall falls once id_ir = NOP_WORD.

Optional Feature:
- Macro: BETA_ID_BYPASS_EN.
- When defined:
  - A source matching ex_dest (≠ 31) takes ex_fwd.
  - Otherwise a source matching mem_dest takes mem_fwd.
  - Otherwise the register file is used. EX has priority over MEM.
  - stall = 1 only when ex_is_load and a used source matches ex_dest (load-use).
  - Forwarded values also feed branch and JMP resolution.
- When undefined: ex_fwd and mem_fwd are ignored; the full interlock above applies.

Decomposition:
- Shared include beta_defs.vh holds:
  - opcode constants;
  - NOP_WORD;
  - PCSEL codes (PCSEL_NEXT = 0, PCSEL_BR = 1, PCSEL_JMP = 2, PCSEL_ILLOP = 3, PCSEL_XADR = 4);
  - RESET/ILLOP/XADR addresses.
- One sub-module: beta_regfile.
  - Two read ports plus one store-data read port, one write port, write-through.
  - R31 hard-wired to 0.

Test Plan:
- Reset asserted while id_ir holds an ADD → ex_ir = 32'h83FFF800, pcsel = 0, stall = 0 immediately, without waiting for a clock edge.
- R1 = 0, BEQ(R1, lit = 3) at if_pc_plus4 = 0x104 → pcsel = 1, branch_target = 0x110; next-cycle id_ir = NOP_WORD.
- R2 = 0x00000123, JMP(R2) → pcsel = 2, jump_target = 0x120; the following fetch is annulled.
- Opcode 0x00 → pcsel = 3; next cycle ex_trap = 1, ex_pc_plus4 = id_pc4.
- ADD R3 then ADD R4,R3,R3 (ex_dest = 3) → without the macro: stall = 1 for 2 cycles with ex_ir = NOP_WORD each, then ex_a = ex_b = R3 from WB write-through. With the macro: no stall, ex_a = ex_fwd = 0x55.
- ex_is_load = 1, ex_dest = 5, ID reads R5 with the macro defined → exactly 1 stall cycle, then ex_a = mem_fwd. A same-cycle wb_we to R31 with data 0xFFFFFFFF → R31 still reads 0.
